// File: rtl/ipif_multi_table_regs.sv
`default_nettype none
// ============================================================================
// Module   : ipif_multi_table_regs
// Purpose  : IPIF slave register front end that gives host software indirect
//            access to TBL_NUM_TABLES external tables with a common row
//            geometry. The host stages a row in the column cells, selects a
//            table, and starts a read or write by writing a row address. The
//            block drives the per-table req/ack handshake, latches read rows
//            into a stable read buffer, and bounds every table access with a
//            timeout.
// Option   : IPIF_TBL_AUTO_INC_EN - when defined, each successful table
//            operation advances the matching row address, wrapping to 0 after
//            TBL_NUM_ROWS-1. A timed-out operation does not advance it.
// Ports    : Bus2IP_*     IPIF slave request (clock, async active-low reset,
//                         address, chip select, direction, data, BEs)
//            IP2Bus_*     read data, one-cycle RdAck/WrAck, Error (with ack)
//            tbl_rd_*     per-table read req/ack, shared row, table rows in
//            tbl_wr_*     per-table write req/ack, shared row, staged row out
// Revision : 1.0 - initial release
// ============================================================================
module ipif_multi_table_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int TBL_NUM_COLS       = 4,
    parameter int TBL_NUM_ROWS       = 16,
    parameter int TBL_NUM_TABLES     = 2,
    parameter int TIMEOUT_CYCLES     = 1024,
    localparam int c_rw = (TBL_NUM_ROWS > 1) ? $clog2(TBL_NUM_ROWS) : 1
) (
    input  logic                                                   Bus2IP_Clk,
    input  logic                                                   Bus2IP_Resetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]                          Bus2IP_Addr,
    input  logic                                                   Bus2IP_CS,
    input  logic                                                   Bus2IP_RNW,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]                          Bus2IP_Data,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]                        Bus2IP_BE,
    output logic [C_S_AXI_DATA_WIDTH-1:0]                          IP2Bus_Data,
    output logic                                                   IP2Bus_RdAck,
    output logic                                                   IP2Bus_WrAck,
    output logic                                                   IP2Bus_Error,
    output logic [TBL_NUM_TABLES-1:0]                              tbl_rd_req,
    input  logic [TBL_NUM_TABLES-1:0]                              tbl_rd_ack,
    output logic [c_rw-1:0]                                        tbl_rd_addr,
    input  logic [TBL_NUM_TABLES*TBL_NUM_COLS*C_S_AXI_DATA_WIDTH-1:0] tbl_rd_data,
    output logic [TBL_NUM_TABLES-1:0]                              tbl_wr_req,
    input  logic [TBL_NUM_TABLES-1:0]                              tbl_wr_ack,
    output logic [c_rw-1:0]                                        tbl_wr_addr,
    output logic [TBL_NUM_COLS*C_S_AXI_DATA_WIDTH-1:0]             tbl_wr_data
);

    localparam int c_dw = C_S_AXI_DATA_WIDTH;
    localparam int c_nc = TBL_NUM_COLS;
    localparam int c_nt = TBL_NUM_TABLES;
    localparam int c_tw = (c_nt > 1) ? $clog2(c_nt) : 1;
    localparam int c_cw = $clog2(TIMEOUT_CYCLES);
    localparam int c_bw = c_dw / 8;
    localparam int c_ww = C_S_AXI_ADDR_WIDTH - 2;

    // Word indices of the control registers that follow the cells.
    localparam logic [c_ww-1:0] c_w_wr_addr = c_ww'(c_nc);
    localparam logic [c_ww-1:0] c_w_rd_addr = c_ww'(c_nc + 1);
    localparam logic [c_ww-1:0] c_w_tbl_sel = c_ww'(c_nc + 2);
    localparam logic [c_ww-1:0] c_w_status  = c_ww'(c_nc + 3);
    localparam logic [c_cw-1:0] c_cnt_last  = c_cw'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PROCESS = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [c_dw-1:0]   r_wr_cell [c_nc];
    logic [c_dw-1:0]   r_rd_buf  [c_nc];
    logic [c_rw-1:0]   r_wr_addr;
    logic [c_rw-1:0]   r_rd_addr;
    logic [c_tw-1:0]   r_tbl_sel;
    logic [1:0]        r_status;
    logic [c_nt-1:0]   r_rd_req;
    logic [c_nt-1:0]   r_wr_req;
    logic              r_op_rd;
    logic [c_cw-1:0]   r_cnt;
    logic [c_dw-1:0]   r_rd_data;
    logic              r_rdack;
    logic              r_wrack;
    logic              r_error;

    logic [c_ww-1:0]   w_word;
    logic              w_is_cell;
    logic              w_is_op;
    logic              w_sel_ack;
    logic              w_rd_strobe;
    logic              w_reg_wr;
    logic              w_start;
    logic              w_op_ok;
    logic              w_op_to;
    logic [c_dw-1:0]   w_rd_data;
    logic              w_rd_err;
    logic              w_wr_err;
    logic [c_nt-1:0]   w_sel_onehot;
    logic [1:0]        w_unused_addr_lsbs;

    assign w_word             = Bus2IP_Addr[C_S_AXI_ADDR_WIDTH-1:2];
    assign w_unused_addr_lsbs = Bus2IP_Addr[1:0];
    assign w_is_cell          = (w_word < c_ww'(c_nc));
    assign w_is_op            = (w_word == c_w_wr_addr) || (w_word == c_w_rd_addr);
    assign w_sel_onehot       = c_nt'(1) << r_tbl_sel;

    // Only the selected table's ack in the active direction is observed.
    assign w_sel_ack = r_op_rd ? tbl_rd_ack[r_tbl_sel] : tbl_wr_ack[r_tbl_sel];

    assign IP2Bus_Data  = r_rd_data;
    assign IP2Bus_RdAck = r_rdack;
    assign IP2Bus_WrAck = r_wrack;
    assign IP2Bus_Error = r_error;
    assign tbl_rd_req   = r_rd_req;
    assign tbl_wr_req   = r_wr_req;
    assign tbl_rd_addr  = r_rd_addr;
    assign tbl_wr_addr  = r_wr_addr;

    for (genvar g = 0; g < c_nc; g++) begin : g_wr_data
        assign tbl_wr_data[g*c_dw +: c_dw] = r_wr_cell[g];
    end

`ifdef IPIF_TBL_AUTO_INC_EN
    // Row count need not be a power of two, so wrap explicitly.
    function automatic logic [c_rw-1:0] f_next_row(input logic [c_rw-1:0] row);
        return (row == c_rw'(TBL_NUM_ROWS - 1)) ? '0 : row + 1'b1;
    endfunction
`endif

    // ------------------------------------------------------------------
    // Read mux and write error decode
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_data = '0;
        w_rd_err  = 1'b0;
        if (w_is_cell) begin
            for (int c = 0; c < c_nc; c++) begin
                if (w_word == c_ww'(c)) begin
                    w_rd_data = r_rd_buf[c];
                end
            end
        end else if (w_word == c_w_wr_addr) begin
            w_rd_data[c_rw-1:0] = r_wr_addr;
        end else if (w_word == c_w_rd_addr) begin
            w_rd_data[c_rw-1:0] = r_rd_addr;
        end else if (w_word == c_w_tbl_sel) begin
            w_rd_data[c_tw-1:0] = r_tbl_sel;
        end else if (w_word == c_w_status) begin
            w_rd_data[1:0] = r_status;
        end else begin
            w_rd_err = 1'b1;
        end
    end

    assign w_wr_err = ((w_word == c_w_tbl_sel) && (Bus2IP_Data >= c_dw'(c_nt)))
                    || (!w_is_cell && (w_word > c_w_status));

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
        if (!Bus2IP_Resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rd_strobe = 1'b0;
        w_reg_wr    = 1'b0;
        w_start     = 1'b0;
        w_op_ok     = 1'b0;
        w_op_to     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (Bus2IP_CS) begin
                    if (Bus2IP_RNW) begin
                        w_rd_strobe = 1'b1;
                        w_state_nxt = S_DONE;
                    end else if (w_is_op) begin
                        w_start     = 1'b1;
                        w_state_nxt = S_PROCESS;
                    end else begin
                        w_reg_wr    = 1'b1;
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_PROCESS: begin
                // Ack takes priority over a timeout on the same cycle.
                if (w_sel_ack) begin
                    w_op_ok     = 1'b1;
                    w_state_nxt = S_DONE;
                end else if (r_cnt == c_cnt_last) begin
                    w_op_to     = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (!Bus2IP_CS) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
        if (!Bus2IP_Resetn) begin
            for (int c = 0; c < c_nc; c++) begin
                r_wr_cell[c] <= '0;
                r_rd_buf[c]  <= '0;
            end
            r_wr_addr <= '0;
            r_rd_addr <= '0;
            r_tbl_sel <= '0;
            r_status  <= '0;
            r_rd_req  <= '0;
            r_wr_req  <= '0;
            r_op_rd   <= 1'b0;
            r_cnt     <= '0;
            r_rd_data <= '0;
            r_rdack   <= 1'b0;
            r_wrack   <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_rdack   <= 1'b0;
            r_wrack   <= 1'b0;
            r_error   <= 1'b0;
            r_rd_data <= '0;

            if (r_state == S_PROCESS) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_rd_strobe) begin
                r_rdack   <= 1'b1;
                r_error   <= w_rd_err;
                r_rd_data <= w_rd_data;
            end

            if (w_reg_wr) begin
                r_wrack <= 1'b1;
                r_error <= w_wr_err;
                for (int c = 0; c < c_nc; c++) begin
                    if (w_word == c_ww'(c)) begin
                        for (int b = 0; b < c_bw; b++) begin
                            if (Bus2IP_BE[b]) begin
                                r_wr_cell[c][8*b +: 8] <= Bus2IP_Data[8*b +: 8];
                            end
                        end
                    end
                end
                if ((w_word == c_w_tbl_sel) && !w_wr_err) begin
                    r_tbl_sel <= Bus2IP_Data[c_tw-1:0];
                end
                if ((w_word == c_w_status) && Bus2IP_Data[0]) begin
                    r_status[0] <= 1'b0;
                end
            end

            if (w_start) begin
                r_cnt <= '0;
                if (w_word == c_w_rd_addr) begin
                    r_op_rd   <= 1'b1;
                    r_rd_addr <= Bus2IP_Data[c_rw-1:0];
                    r_rd_req  <= w_sel_onehot;
                end else begin
                    r_op_rd   <= 1'b0;
                    r_wr_addr <= Bus2IP_Data[c_rw-1:0];
                    r_wr_req  <= w_sel_onehot;
                end
            end

            if (w_op_ok) begin
                r_rd_req    <= '0;
                r_wr_req    <= '0;
                r_wrack     <= 1'b1;
                r_status[1] <= 1'b0;
                if (r_op_rd) begin
                    for (int c = 0; c < c_nc; c++) begin
                        r_rd_buf[c] <= tbl_rd_data[(int'(r_tbl_sel) * c_nc + c) * c_dw +: c_dw];
                    end
                end
`ifdef IPIF_TBL_AUTO_INC_EN
                if (r_op_rd) begin
                    r_rd_addr <= f_next_row(r_rd_addr);
                end else begin
                    r_wr_addr <= f_next_row(r_wr_addr);
                end
`endif
            end

            if (w_op_to) begin
                r_rd_req <= '0;
                r_wr_req <= '0;
                r_wrack  <= 1'b1;
                r_error  <= 1'b1;
                r_status <= 2'b11;
            end
        end
    end

endmodule
`default_nettype wire
